// File: rtl/mbe_traffic_master.sv
// Self-test initiator for the signed MBE multiplier wrapper: preamble + LFSR operands, golden-checked products.
// Optional build macro MBE_MASTER_BACKPRESSURE_EN adds pseudo-random stalls on both handshakes.
module mbe_traffic_master #(
  parameter int unsigned N          = 32,
  parameter int unsigned NUM_TXN    = 256,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] SEED       = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [N-1:0]     a_o,
  output logic [N-1:0]     b_o,
  output logic             in_valid_o,
  input  logic             in_ready_i,
  input  logic [2*N-1:0]   res_i,
  input  logic             out_valid_i,
  output logic             out_ready_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_cnt,
  output logic             proto_err,
  output logic [N-1:0]     first_err_a,
  output logic [N-1:0]     first_err_b
);

  localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W     = PTR_W + 1;
  localparam int unsigned W2        = 2 * N;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [15:0] NUM_TXN_C = 16'(NUM_TXN);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [N-1:0] MSB_ONLY = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] ALL_ONES = {N{1'b1}};
  localparam logic [N-1:0] ONE_N    = N'(1);
  localparam logic [N-1:0] MAX_POS  = {1'b0, {(N-1){1'b1}}};

  if (NUM_TXN < 4 || NUM_TXN > 65535) begin : g_bad_num_txn
    $error("mbe_traffic_master: NUM_TXN must be in 4..65535");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mbe_traffic_master: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  state_e            state_q, state_d;
  logic [15:0]       sent_q, sent_d, recv_q, recv_d;
  logic [31:0]       lfsr_q, lfsr_d;
  logic [N-1:0]      a_q, a_d, b_q, b_d;
  logic              in_valid_q, in_valid_d, out_ready_q, out_ready_d;
  logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [15:0]       err_cnt_q, err_cnt_d;
  logic              proto_err_q, proto_err_d;
  logic [N-1:0]      first_a_q, first_a_d, first_b_q, first_b_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [N-1:0]      fifo_a_q [FIFO_DEPTH];
  logic [N-1:0]      fifo_b_q [FIFO_DEPTH];

  logic              go, push, hs_out, pop, mismatch;
  logic [N-1:0]      head_a, head_b;
  logic [W2-1:0]     a_ext, b_ext, golden;

`ifdef MBE_MASTER_BACKPRESSURE_EN
  logic [7:0]        lfsr8_q, lfsr8_d;
  logic              pending;
`endif

  // Next-state, FIFO bookkeeping, checking and registered-output decode
  always_comb begin
    state_d     = state_q;
    sent_d      = sent_q;
    recv_d      = recv_q;
    lfsr_d      = lfsr_q;
    a_d         = a_q;
    b_d         = b_q;
    err_cnt_d   = err_cnt_q;
    proto_err_d = proto_err_q;
    first_a_d   = first_a_q;
    first_b_d   = first_b_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    go       = start && (state_q == S_IDLE || state_q == S_DONE);
    push     = in_valid_q && in_ready_i;
    hs_out   = out_valid_i && out_ready_q;
    pop      = hs_out && (count_q != '0);
    head_a   = fifo_a_q[rd_ptr_q];
    head_b   = fifo_b_q[rd_ptr_q];
    a_ext    = {{N{head_a[N-1]}}, head_a};
    b_ext    = {{N{head_b[N-1]}}, head_b};
    golden   = a_ext * b_ext;
    mismatch = pop && (res_i != golden);

    if (go) begin
      sent_d      = '0;
      recv_d      = '0;
      err_cnt_d   = '0;
      proto_err_d = 1'b0;
      first_a_d   = '0;
      first_b_d   = '0;
      a_d         = '0;
      b_d         = '0;
    end else begin
      if (push) begin
        sent_d   = sent_q + 16'd1;
        lfsr_d   = lfsr_step(lfsr_step(lfsr_q));
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        // Present the pair for the new index right away for 1/cycle throughput
        case (sent_d)
          16'd1:   begin a_d = MSB_ONLY; b_d = MSB_ONLY; end
          16'd2:   begin a_d = ALL_ONES; b_d = ONE_N;    end
          16'd3:   begin a_d = MAX_POS;  b_d = MSB_ONLY; end
          default: begin a_d = N'(lfsr_d); b_d = N'(lfsr_step(lfsr_d)); end
        endcase
      end
      if (pop) begin
        recv_d   = recv_q + 16'd1;
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (hs_out && count_q == '0) proto_err_d = 1'b1;
      if (mismatch) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        if (err_cnt_q == '0) begin
          first_a_d = head_a;
          first_b_d = head_b;
        end
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    case (state_q)
      S_IDLE, S_DONE: if (go) state_d = S_RUN;
      S_RUN:   if (sent_d == NUM_TXN_C) state_d = (recv_d == NUM_TXN_C) ? S_DONE : S_DRAIN;
      S_DRAIN: if (recv_d == NUM_TXN_C) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase

    in_valid_d  = (state_d == S_RUN) && (sent_d < NUM_TXN_C) && (count_d < DEPTH_C);
    out_ready_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    busy_d      = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d      = (state_d == S_DONE);
    pass_d      = done_d && (err_cnt_d == '0) && !proto_err_d;

`ifdef MBE_MASTER_BACKPRESSURE_EN
    // A pair already on the bus is never withdrawn; gaps only precede new pairs
    pending = in_valid_q && !in_ready_i;
    lfsr8_d = lfsr8_q;
    if (state_q == S_RUN || state_q == S_DRAIN)
      lfsr8_d = {1'b0, lfsr8_q[7:1]} ^ (lfsr8_q[0] ? 8'hB8 : 8'h00);
    out_ready_d = out_ready_d && (lfsr8_d[1:0] != 2'b00);
    in_valid_d  = in_valid_d && (pending || (lfsr8_d[7:6] != 2'b00));
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sent_q      <= '0;
      recv_q      <= '0;
      lfsr_q      <= SEED_EFF;
      a_q         <= '0;
      b_q         <= '0;
      in_valid_q  <= 1'b0;
      out_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_cnt_q   <= '0;
      proto_err_q <= 1'b0;
      first_a_q   <= '0;
      first_b_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sent_q      <= sent_d;
      recv_q      <= recv_d;
      lfsr_q      <= lfsr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      in_valid_q  <= in_valid_d;
      out_ready_q <= out_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      err_cnt_q   <= err_cnt_d;
      proto_err_q <= proto_err_d;
      first_a_q   <= first_a_d;
      first_b_q   <= first_b_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

`ifdef MBE_MASTER_BACKPRESSURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr8_q <= 8'h5A;
    else        lfsr8_q <= lfsr8_d;
  end
`endif

  // In-flight operand storage
  always_ff @(posedge clk) begin
    if (push && !go) begin
      fifo_a_q[wr_ptr_q] <= a_q;
      fifo_b_q[wr_ptr_q] <= b_q;
    end
  end

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign in_valid_o  = in_valid_q;
  assign out_ready_o = out_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign err_cnt     = err_cnt_q;
  assign proto_err   = proto_err_q;
  assign first_err_a = first_a_q;
  assign first_err_b = first_b_q;

endmodule

// File: doc/mbe_traffic_master.md
Name: mbe_traffic_master

Overview:
- Synthesizable initiator for the signed MBE multiplier wrapper; drives the operand side (A, B, valid/ready) and consumes the result side (data, valid/ready).
- Generates a fixed corner-case preamble followed by LFSR operand pairs, tracks in-flight operands in a small FIFO, and checks every returned product against a golden signed multiply.
- Used for on-board and emulation self-test of the Dadda/MBE datapath; reports pass/fail and the first mismatch.

Parameters:
- N, 32, operand width; the result is 2N bits.
- NUM_TXN, 256, total transactions per run including the preamble; legal range 4..65535.
- FIFO_DEPTH, 4, maximum in-flight operand pairs; power of two, at least 2.
- SEED, 32'hACE1_2468, LFSR seed; must be non-zero, and 0 is replaced by 1.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, one-cycle pulse; begins a run when in IDLE or DONE.
- a_o, output, N, operand A to the DUT.
- b_o, output, N, operand B to the DUT.
- in_valid_o, output, 1, operand pair valid.
- in_ready_i, input, 1, DUT ready for operands.
- res_i, input, 2N, product from the DUT.
- out_valid_i, input, 1, product valid.
- out_ready_o, output, 1, master ready to take a product.
- busy, output, 1, high in RUN and DRAIN.
- done, output, 1, high in DONE.
- pass, output, 1, meaningful only while done is high: err_cnt==0 and no protocol error.
- err_cnt, output, 16, count of mismatches; saturates at 16'hFFFF.
- proto_err, output, 1, sticky; set when a product arrives with the FIFO empty.
- first_err_a, output, N, A operand of the first mismatch.
- first_err_b, output, N, B operand of the first mismatch.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; FIFO empty; LFSR=SEED; sent/recv counters cleared. Assertion mid-run aborts the run immediately, with no drain.
- FSM:
  - IDLE: on start go to RUN.
  - DONE: on start, clear err_cnt, proto_err, first_err_* and the counters, then go to RUN.
  - RUN: go to DRAIN when sent==NUM_TXN.
  - DRAIN: go to DONE when recv==NUM_TXN.
  - start is ignored in RUN and DRAIN.
- Operand generation:
  - Preamble, in order: (0,0), (100000…0, 100000…0), (all-ones, 1), (011…1, 100…0).
  - Thereafter A = LFSR state, B = LFSR state after one further step. Each transfer advances the LFSR twice.
  - The LFSR is a 32-bit Galois LFSR with taps 32,22,2,1; for N≠32, the low N bits are used.
- Send handshake:
  - in_valid_o is asserted in RUN when sent<NUM_TXN and the FIFO is not full.
  - Transfer occurs on a rising edge with in_valid_o && in_ready_i.
  - a_o and b_o are held stable while in_valid_o=1 and !in_ready_i.
  - On transfer: push {a,b}, sent++, and present the next pair in the next cycle, giving back-to-back throughput of 1 per cycle.
- Receive handshake:
  - out_ready_o=1 in RUN and DRAIN (see Optional Feature).
  - On out_valid_i && out_ready_o, pop the FIFO, recv++, and compare res_i to $signed(a)*$signed(b) computed at full 2N width.
  - On mismatch, err_cnt++ (saturating). If this is the first mismatch, latch first_err_a and first_err_b.
- Simultaneous push and pop: occupancy is unchanged. A push is allowed when the FIFO is full only if a pop occurs in the same cycle.
- Product received with the FIFO empty: set proto_err, do not change recv, perform no compare.
- Latency: the first in_valid_o is asserted 1 cycle after start is sampled. done is asserted 1 cycle after the final product handshake.
- Counters are 16 bits wide. NUM_TXN above 65535 is illegal and flagged by an elaboration assertion.

Optional Feature:
- Macro: MBE_MASTER_BACKPRESSURE_EN.
- Defined:
  - A separate 8-bit LFSR (seed 8'h5A) advances every cycle in RUN and DRAIN.
  - out_ready_o = (lfsr8[1:0] != 2'b00), giving about 25% stall cycles.
  - in_valid_o is additionally dropped on cycles where lfsr8[7:6]==2'b00, but only when no pair is pending. A pair already presented stays valid until transferred.
- Undefined: out_ready_o is constantly 1 in RUN and DRAIN, and in_valid_o has no extra gaps.

Test Plan:
- Correct DUT, NUM_TXN=4, start pulse -> preamble products 0, 2^62, -1, -(2^31-1)·2^31 in that order; done=1, pass=1, err_cnt=0.
- Correct DUT, NUM_TXN=256, in_ready_i toggling every 3 cycles -> operands held stable while stalled; done after 256 products; pass=1.
- DUT model returning product XOR 1 on the 10th transaction only -> err_cnt=1; first_err_a and first_err_b equal the 10th pair; pass=0.
- Product injected while the FIFO is empty -> proto_err=1 and sticky; recv unchanged.
- rst_n pulsed low mid-RUN with 2 pairs in flight -> all outputs 0, state IDLE. A new start then replays the preamble from (0,0).
- Compiled with MBE_MASTER_BACKPRESSURE_EN -> out_ready_o shows stalls; the DUT holds data; NUM_TXN=64 completes with pass=1.
